// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg
//   Shared definitions for the memory-port arbiter: requester IDs recorded in
//   the response-order FIFO, the fixed inst access size and the arbiter FSM
//   state encoding.
package mem_req_arbiter_pkg;

    // Requester ID stored per accepted transaction
    localparam logic REQ_INST = 1'b0;
    localparam logic REQ_DATA = 1'b1;

    // Instruction fetches are always full-word reads
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_HOLD_I = 2'd1,
        ARB_HOLD_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_req_arbiter_id_fifo.sv
// id_fifo
//   Synchronous 1-bit-wide FIFO holding the requester ID of every accepted,
//   not yet answered transaction, oldest at the head.
// Ports
//   clk, rst  clock, synchronous active-high reset (empties the FIFO)
//   push      write push_id at the tail (dropped when full unless popping)
//   push_id   requester ID to record
//   pop       remove the head entry (ignored when empty)
//   full      count == DEPTH
//   empty     count == 0
//   head      ID at the head (valid when !empty)
//   count     entries held, 0..DEPTH
module id_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          push_id,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic          head,
    output logic [CW-1:0] count
);

    logic          ids [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = ids[rd_ptr];
    assign do_pop  = pop && !empty;
    // A push while full is legal only when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    // Storage needs no reset; entries are only read once counted
    always_ff @(posedge clk) begin
        if (do_push) ids[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Shares one SRAM-like memory port between the fetch requester (inst,
//   read-only) and the MEM-stage requester (data, read/write). One address
//   phase is granted at a time and the grant is held until mem_addr_ok.
//   Each accepted transaction's requester is queued so in-order responses
//   (mem_data_ok/mem_rdata) are routed back to whoever issued them.
//
// Handshake: a requester raises *_req with stable payload and keeps it until
//   it sees *_addr_ok in the same cycle; that cycle is the acceptance. The
//   downstream port follows the same rule on mem_req/mem_addr_ok, and answers
//   with one mem_data_ok per accepted address, strictly in acceptance order.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   inst_req/inst_addr            fetch request (word read)
//   inst_addr_ok/inst_data_ok/inst_rdata   fetch accept / response
//   data_req/wr/size/addr/wstrb/wdata      MEM-stage request
//   data_addr_ok/data_data_ok/data_rdata   MEM-stage accept / response
//   mem_req/wr/size/addr/wstrb/wdata       shared downstream request
//   mem_addr_ok/mem_data_ok/mem_rdata      downstream accept / response
//   outstanding                   accepted-but-unanswered transactions
//   proto_err                     sticky: response arrived with none outstanding
//   arb_state                     current FSM state (debug)
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 4,
    parameter  int STARVE_LIMIT    = 3,
    localparam int OW              = $clog2(MAX_OUTSTANDING) + 1,
    localparam int SW              = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          inst_req,
    input  logic [31:0]   inst_addr,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,
    output logic [31:0]   inst_rdata,

    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [31:0]   data_addr,
    input  logic [3:0]    data_wstrb,
    input  logic [31:0]   data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [31:0]   data_rdata,

    output logic          mem_req,
    output logic          mem_wr,
    output logic [1:0]    mem_size,
    output logic [31:0]   mem_addr,
    output logic [3:0]    mem_wstrb,
    output logic [31:0]   mem_wdata,
    input  logic          mem_addr_ok,
    input  logic          mem_data_ok,
    input  logic [31:0]   mem_rdata,

    output logic [OW-1:0] outstanding,
    output logic          proto_err,
    output arb_state_t    arb_state
);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic          gnt_valid;
    logic          gnt_id;
    logic          accept;
    logic [SW-1:0] starve;
    logic          starve_max;
    logic          fifo_full;
    logic          fifo_empty;
    logic          head_id;
    logic          resp_valid;

    assign arb_state  = state_q;
    assign starve_max = (starve == SW'(STARVE_LIMIT));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= ARB_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: grant selection and next state ----------------
    // Fullness is only consulted in IDLE; a locked grant was admitted while
    // there was room, and responses only ever free entries.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = REQ_INST;
        state_d   = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (!fifo_full) begin
                    if (inst_req && starve_max) begin
                        gnt_valid = 1'b1;
                        gnt_id    = REQ_INST;
                    end else if (data_req) begin
                        gnt_valid = 1'b1;
                        gnt_id    = REQ_DATA;
                    end else if (inst_req) begin
                        gnt_valid = 1'b1;
                        gnt_id    = REQ_INST;
                    end
                end
            end
            ARB_HOLD_I: begin
                gnt_valid = 1'b1;
                gnt_id    = REQ_INST;
            end
            ARB_HOLD_D: begin
                gnt_valid = 1'b1;
                gnt_id    = REQ_DATA;
            end
            default: ;
        endcase

        accept = gnt_valid && mem_addr_ok;

        if (gnt_valid && !mem_addr_ok)
            state_d = (gnt_id == REQ_INST) ? ARB_HOLD_I : ARB_HOLD_D;
        else if (accept)
            state_d = ARB_IDLE;
    end

    // ---------------- Request mux onto the shared port ----------------
    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = 32'd0;
        mem_wstrb = 4'd0;
        mem_wdata = 32'd0;
        if (gnt_valid) begin
            mem_req = 1'b1;
            if (gnt_id == REQ_INST) begin
                mem_addr = inst_addr;
                mem_size = MEM_SIZE_WORD;
            end else begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_addr  = data_addr;
                mem_wstrb = data_wstrb;
                mem_wdata = data_wdata;
            end
        end
    end

    assign inst_addr_ok = accept && (gnt_id == REQ_INST);
    assign data_addr_ok = accept && (gnt_id == REQ_DATA);

    // ---------------- Starvation counter ----------------
    // Counts data wins while inst is waiting; once at the limit the next
    // IDLE arbitration goes to inst regardless of data_req.
    always_ff @(posedge clk) begin
        if (rst || !inst_req)
            starve <= '0;
        else if (inst_addr_ok)
            starve <= '0;
        else if (data_addr_ok && !starve_max)
            starve <= starve + SW'(1);
    end

    // ---------------- Response-order FIFO ----------------
    id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .push_id (gnt_id),
        .pop     (mem_data_ok),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head_id),
        .count   (outstanding)
    );

    // ---------------- Response demux ----------------
    // A response with nothing outstanding is dropped and flagged.
    assign resp_valid   = mem_data_ok && !fifo_empty;
    assign inst_data_ok = resp_valid && (head_id == REQ_INST);
    assign data_data_ok = resp_valid && (head_id == REQ_DATA);
    assign inst_rdata   = inst_data_ok ? mem_rdata : 32'd0;
    assign data_rdata   = data_data_ok ? mem_rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (rst)
            proto_err <= 1'b0;
        else if (mem_data_ok && fifo_empty)
            proto_err <= 1'b1;
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter
//   Directed scenarios (starvation forcing, full blocking, stray response)
//   plus randomized traffic, all checked against a transaction-level model:
//   a queue of requester IDs in acceptance order, an integer starve count
//   and a "locked requester" variable for a stalled address phase.
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

    localparam int MAX_OUT = 4;
    localparam int STARVE  = 3;

    // ---------------- DUT signals ----------------
    logic        clk, rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic [2:0]  outstanding;
    logic        proto_err;
    arb_state_t  arb_state;

    mem_req_arbiter #(
        .MAX_OUTSTANDING (MAX_OUT),
        .STARVE_LIMIT    (STARVE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .outstanding  (outstanding),
        .proto_err    (proto_err),
        .arb_state    (arb_state)
    );

    // ---------------- Clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- Reference model state ----------------
    localparam int WHO_NONE = 0;
    localparam int WHO_INST = 1;
    localparam int WHO_DATA = 2;

    logic [0:0] exp_q[$];   // requester IDs of accepted, unanswered transactions
    int         lock_who;   // requester holding a stalled address phase
    int         starve_m;   // data wins while inst has been waiting
    bit         perr_m;
    int         gnt_m;      // winner for the current cycle
    bit         acc_i, acc_d;

    int n_vec, n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        lock_who = WHO_NONE;
        starve_m = 0;
        perr_m   = 1'b0;
        acc_i    = 1'b0;
        acc_d    = 1'b0;
    endtask

    // Predict this cycle's combinational behaviour from the current inputs
    // and compare every observable output.
    task automatic model_check();
        logic head;
        bit   exp_ido, exp_ddo;
        if (lock_who != WHO_NONE)                 gnt_m = lock_who;
        else if (exp_q.size() >= MAX_OUT)         gnt_m = WHO_NONE;
        else if (inst_req && starve_m == STARVE)  gnt_m = WHO_INST;
        else if (data_req)                        gnt_m = WHO_DATA;
        else if (inst_req)                        gnt_m = WHO_INST;
        else                                      gnt_m = WHO_NONE;

        check("mem_req", 32'(mem_req), 32'(gnt_m != WHO_NONE));
        if (gnt_m == WHO_INST) begin
            check("inst_mem_addr",  mem_addr,        inst_addr);
            check("inst_mem_wr",    32'(mem_wr),     32'd0);
            check("inst_mem_size",  32'(mem_size),   32'd2);
            check("inst_mem_wstrb", 32'(mem_wstrb),  32'd0);
        end else if (gnt_m == WHO_DATA) begin
            check("data_mem_addr",  mem_addr,        data_addr);
            check("data_mem_wr",    32'(mem_wr),     32'(data_wr));
            check("data_mem_size",  32'(mem_size),   32'(data_size));
            check("data_mem_wstrb", 32'(mem_wstrb),  32'(data_wstrb));
            check("data_mem_wdata", mem_wdata,       data_wdata);
        end else begin
            check("idle_mem_addr",  mem_addr,        32'd0);
        end

        acc_i = (gnt_m == WHO_INST) && mem_addr_ok;
        acc_d = (gnt_m == WHO_DATA) && mem_addr_ok;
        check("inst_addr_ok", 32'(inst_addr_ok), 32'(acc_i));
        check("data_addr_ok", 32'(data_addr_ok), 32'(acc_d));

        head    = (exp_q.size() > 0) ? exp_q[0] : REQ_INST;
        exp_ido = mem_data_ok && exp_q.size() > 0 && head == REQ_INST;
        exp_ddo = mem_data_ok && exp_q.size() > 0 && head == REQ_DATA;
        check("inst_data_ok", 32'(inst_data_ok), 32'(exp_ido));
        check("data_data_ok", 32'(data_data_ok), 32'(exp_ddo));
        if (exp_ido) check("inst_rdata", inst_rdata, mem_rdata);
        if (exp_ddo) check("data_rdata", data_rdata, mem_rdata);

        check("outstanding", 32'(outstanding), 32'(exp_q.size()));
        check("proto_err",   32'(proto_err),   32'(perr_m));
    endtask

    // Advance the model by one clock using the inputs held across the edge.
    task automatic model_commit();
        if (rst) begin
            model_reset();
            return;
        end
        if (mem_data_ok) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            else                  perr_m = 1'b1;
        end
        if (acc_i) exp_q.push_back(REQ_INST);
        if (acc_d) exp_q.push_back(REQ_DATA);
        lock_who = (gnt_m != WHO_NONE && !mem_addr_ok) ? gnt_m : WHO_NONE;
        if (!inst_req)                         starve_m = 0;
        else if (acc_i)                        starve_m = 0;
        else if (acc_d && starve_m < STARVE)   starve_m = starve_m + 1;
    endtask

    // ---------------- Driver tasks ----------------
    task automatic idle_inputs();
        inst_req    = 1'b0;
        inst_addr   = 32'd0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd0;
        data_addr   = 32'd0;
        data_wstrb  = 4'd0;
        data_wdata  = 32'd0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'd0;
    endtask

    // Inputs change at posedge+1; outputs sampled at posedge+4.
    task automatic settle();
        #3;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        check("rst_mem_req",      32'(mem_req),      32'd0);
        check("rst_mem_addr",     mem_addr,          32'd0);
        check("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        check("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
        check("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
        check("rst_data_data_ok", 32'(data_data_ok), 32'd0);
        check("rst_inst_rdata",   inst_rdata,        32'd0);
        check("rst_data_rdata",   data_rdata,        32'd0);
        check("rst_outstanding",  32'(outstanding),  32'd0);
        check("rst_proto_err",    32'(proto_err),    32'd0);
        check("rst_arb_state",    32'(arb_state),    32'(ARB_IDLE));
        rst = 1'b0;
    endtask

    // Requesters keep a pending request stable until it is accepted; the
    // downstream only answers when something is outstanding.
    task automatic drive_random();
        if (!inst_req || acc_i) begin
            inst_req  = ($urandom_range(0, 99) < 60);
            inst_addr = $urandom() & 32'hFFFF_FFFC;
        end
        if (!data_req || acc_d) begin
            data_req   = ($urandom_range(0, 99) < 75);
            data_wr    = 1'($urandom_range(0, 1));
            data_size  = 2'($urandom_range(0, 2));
            data_addr  = $urandom();
            data_wstrb = 4'($urandom_range(0, 15));
            data_wdata = $urandom();
        end
        mem_addr_ok = ($urandom_range(0, 99) < 60);
        mem_data_ok = (exp_q.size() > 0) && ($urandom_range(0, 99) < 50);
        mem_rdata   = $urandom();
    endtask

    // ---------------- Stimulus ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        gnt_m = WHO_NONE;
        do_reset();

        // Both requesting, downstream always ready: three data wins, then inst forced.
        inst_req    = 1'b1;
        inst_addr   = 32'h0000_1000;
        data_req    = 1'b1;
        data_wr     = 1'b0;
        data_size   = 2'd2;
        data_addr   = 32'h0000_2000;
        mem_addr_ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            check("starve_data_win", 32'(data_addr_ok), 32'(c < 3));
            check("starve_inst_win", 32'(inst_addr_ok), 32'(c == 3));
            tick();
            data_addr = data_addr + 32'd4;
        end
        inst_req = 1'b0;

        // Four outstanding: no grant despite a pending data request.
        settle();
        check("full_no_req",      32'(mem_req),     32'd0);
        check("full_outstanding", 32'(outstanding), 32'd4);
        tick();

        // One response (oldest was a data read) frees a slot for next cycle.
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hCAFE_0001;
        settle();
        check("full_resp_data_ok", 32'(data_data_ok), 32'd1);
        check("full_resp_rdata",   data_rdata,        32'hCAFE_0001);
        check("full_resp_inst_ok", 32'(inst_data_ok), 32'd0);
        check("full_still_blocked", 32'(mem_req),     32'd0);
        tick();
        mem_data_ok = 1'b0;
        settle();
        check("full_regrant",     32'(data_addr_ok), 32'd1);
        check("full_after_pop",   32'(outstanding),  32'd3);
        tick();

        // Drain everything (bounded).
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
            mem_data_ok = 1'b1;
            mem_rdata   = $urandom();
            settle();
            tick();
        end
        mem_data_ok = 1'b0;
        settle();
        check("drained", 32'(outstanding), 32'd0);
        tick();

        // Stray response with nothing outstanding.
        do_reset();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0000_1234;
        settle();
        check("stray_inst_ok", 32'(inst_data_ok), 32'd0);
        check("stray_data_ok", 32'(data_data_ok), 32'd0);
        tick();
        mem_data_ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("proto_err_sticky", 32'(proto_err), 32'd1);
            tick();
        end
        do_reset();

        // Randomized traffic, with a reset landing mid-stream.
        for (int i = 0; i < 1500; i++) begin
            drive_random();
            settle();
            tick();
        end
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            drive_random();
            settle();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
